led_spinner_core: RTL and testbench
===================================

Name: led_spinner_core

Overview:
- Roulette-style "LED spinner" core for the tt_um_timba307_LEDSpinner tile.
- A lit LED steps around a 6-position ring at a selectable rate.
- A stop input freezes the ring. The frozen position is then compared against six player guess inputs, and the block shows win or lose.
- Sits directly under the TinyTapeout wrapper, which only inverts rst_n into rst.

Parameters:
- CLK_HZ, 50_000_000: system clock frequency; all divider reload values derive from it.
- NUM_POS, 6: ring positions; fixed at 6, because the guess inputs are 6 bits wide.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- ui_in  in  8  [3:0] speed code; [6] direction (optional feature only); [7] stop (1 = stop wheel); [5:4] unused.
- uio_in  in  8  [5:0] guess bits, one per ring position; [7:6] unused.
- ena  in  1  tile enable; ignored.
- uo_out  out  8  [5:0] one-hot ring position; [6] running; [7] win.
- uio_out  out  8  [6] lose; [7] result_valid; [5:0] always 0.
- uio_oe  out  8  constant 8'b1100_0000.

Behaviour:
- Reset (async, rst=1):
  - pos=0, divider=0, all synchronizers=0, result_valid=0, win=0, lose=0.
  - Outputs: uo_out=8'h41, uio_out=8'h00, uio_oe=8'hC0.
- Input sync: ui_in[7] and uio_in[5:0] each pass through a 2-flop synchronizer (stop_s, guess_s). ui_in[3:0] is used unsynchronized; it is quasi-static.
- Speed decode, as step rate and reload value N = CLK_HZ/rate:
  - 4'b0001: 10 Hz, N=5_000_000.
  - 4'b0010: 100 Hz, N=500_000.
  - 4'b0100: 1 kHz, N=50_000.
  - 4'b1000: 10 kHz, N=5_000.
  - Any other code, including 0000 and multi-hot codes such as 0101: 1 kHz default.
- Divider:
  - 23-bit counter. While running, it increments every clock.
  - When counter >= N-1, the counter goes to 0 and a step pulse fires. Using >= keeps a speed change to a faster rate from skipping a step past terminal count.
- Step:
  - pos advances 0→1→…→5→0; wraps 5→0.
  - uo_out[5:0] = 1<<pos, exactly one bit high at all times.
- running = ~stop_s, driven on uo_out[6].
- While stop_s=1:
  - Divider and pos hold.
  - On resume, the divider continues from its held value; it is not reset.
- Result:
  - On the first clock where stop_s=1 and result_valid=0: result_valid<=1, win<=guess_s[pos], lose<=~guess_s[pos].
  - Latency: ui_in[7] rises to result_valid high in 3 clock edges.
  - Guess changes while stopped do not alter the latched result.
- Resume: the clock on which stop_s returns to 0 clears result_valid, win and lose.
- Simultaneous events: a step pulse and stop_s rising on the same edge → the stop wins; pos does not advance. The result uses the pre-step pos.
- Multiple guesses set: win if the stopped position's bit is set. All six set → always win.
- No guesses set → always lose.
- Reset mid-spin or mid-result: returns to reset values immediately, asynchronously.

Optional Feature:
- Macro LEDSPINNER_DIR_EN.
- When defined: ui_in[6]=1 makes pos step in reverse (0→5→4…→0); ui_in[6]=0 steps forward. Direction is sampled at each step pulse.
- When undefined: ui_in[6] is ignored and the ring always steps forward.

Test Plan:
- Reset held 200 ns, then released with ui_in=0, uio_in=0:
  - During reset: uo_out=8'h41, uio_oe=8'hC0, uio_out=0.
  - Immediately after release: still pos 0.
- Speed code 4'b0101 (invalid), no guesses, run 3.5 ms:
  - Exactly 3 steps at the 1 kHz default, so uo_out[5:0]=6'b001000.
  - 6.5 ms after release: wrap observed, uo_out[5:0]=6'b000001.
- Stop with no guesses: set ui_in[7]=1.
  - Within 3 clocks: uo_out[6]=0, uio_out[7]=1, uio_out[6]=1 (lose), uo_out[7]=0.
  - pos unchanged over a further 5 ms.
- Release stop, uio_in[5:0]=6'b111111, run 5 ms:
  - Spinning resumes; result_valid=0 within 3 clocks.
  - Then stop again → win=1, lose=0 regardless of pos, held for 10 ms.
- Speed code 4'b1000 for 1 ms → 10 steps; pos advanced by 10 mod 6 = 4.
- LEDSPINNER_DIR_EN defined, ui_in[6]=1, default speed, 1 ms from pos 0 → uo_out[5:0]=6'b100000 (pos 5).

Source files
------------

// File: rtl/led_spinner_core.sv
// led_spinner_core: 6-position LED roulette with stop, guess compare and win/lose result.
// Optional LEDSPINNER_DIR_EN: ui_in[6] selects reverse stepping.
module led_spinner_core #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int NUM_POS = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  input  logic       ena,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  localparam logic [22:0] R10  = 23'(CLK_HZ / 10 - 1);
  localparam logic [22:0] R100 = 23'(CLK_HZ / 100 - 1);
  localparam logic [22:0] R1K  = 23'(CLK_HZ / 1000 - 1);
  localparam logic [22:0] R10K = 23'(CLK_HZ / 10000 - 1);
  localparam logic [2:0]  LAST = 3'(NUM_POS - 1);

  logic [22:0] cnt_q, cnt_d, reload;
  logic [2:0]  pos_q, pos_d;
  logic        stop_m_q, stop_m_d, stop_s_q, stop_s_d;
  logic [5:0]  guess_m_q, guess_m_d, guess_s_q, guess_s_d, onehot;
  logic        rv_q, rv_d, win_q, win_d, lose_q, lose_d;
  logic        tc, step, hit, dir;
  logic        unused_ok;

`ifdef LEDSPINNER_DIR_EN
  assign dir = ui_in[6];
`else
  assign dir = 1'b0;
`endif
  assign unused_ok = &{1'b0, ena, ui_in[6:4], uio_in[7:6]};

  always_comb begin
    reload = ui_in[3:0] == 4'b0001 ? R10 :
             ui_in[3:0] == 4'b0010 ? R100 :
             ui_in[3:0] == 4'b1000 ? R10K : R1K;
    // >= so a switch to a faster rate never runs past terminal count
    tc        = cnt_q >= reload;
    step      = ~stop_s_q & tc;
    cnt_d     = stop_s_q ? cnt_q : tc ? 23'd0 : cnt_q + 23'd1;
    pos_d     = ~step ? pos_q :
                dir ? (pos_q == 3'd0 ? LAST : pos_q - 3'd1) :
                (pos_q == LAST ? 3'd0 : pos_q + 3'd1);
    onehot    = 6'b1 << pos_q;
    hit       = |(guess_s_q & onehot);
    stop_m_d  = ui_in[7];
    stop_s_d  = stop_m_q;
    guess_m_d = uio_in[5:0];
    guess_s_d = guess_m_q;
    // result latches on the first stopped clock and clears as soon as the wheel runs
    rv_d      = stop_s_q;
    win_d     = stop_s_q & (rv_q ? win_q : hit);
    lose_d    = stop_s_q & (rv_q ? lose_q : ~hit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      pos_q     <= '0;
      stop_m_q  <= 1'b0;
      stop_s_q  <= 1'b0;
      guess_m_q <= '0;
      guess_s_q <= '0;
      rv_q      <= 1'b0;
      win_q     <= 1'b0;
      lose_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pos_q     <= pos_d;
      stop_m_q  <= stop_m_d;
      stop_s_q  <= stop_s_d;
      guess_m_q <= guess_m_d;
      guess_s_q <= guess_s_d;
      rv_q      <= rv_d;
      win_q     <= win_d;
      lose_q    <= lose_d;
    end
  end

  assign uo_out  = {win_q, ~stop_s_q, onehot};
  assign uio_out = {rv_q, lose_q, 6'b0};
  assign uio_oe  = 8'hC0;
endmodule

// File: tb/tb_led_spinner_core.sv
// tb_led_spinner_core: random and directed stimulus against a cycle-count model of the spinner.
module tb_led_spinner_core;
  localparam int CLK_HZ = 50_000;

  logic       clk = 1'b0, rst = 1'b1, ena = 1'b1;
  logic [7:0] ui_in = 8'h00, uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;
  int total = 0, bad = 0;

  led_spinner_core #(.CLK_HZ(CLK_HZ)) dut (
    .clk(clk), .rst(rst), .ui_in(ui_in), .uio_in(uio_in), .ena(ena),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #10 clk = ~clk;

  int       m_pos, m_el;
  bit       m_sm, m_ss, m_rv, m_win;
  bit [5:0] m_gm, m_gs;
  bit       rev;

`ifdef LEDSPINNER_DIR_EN
  assign rev = ui_in[6];
`else
  assign rev = 1'b0;
`endif

  function automatic int period(input logic [3:0] code);
    case (code)
      4'b0001: return CLK_HZ / 10;
      4'b0010: return CLK_HZ / 100;
      4'b1000: return CLK_HZ / 10000;
      default: return CLK_HZ / 1000;
    endcase
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin : model
    int ne, np;
    bit stepped;
    if (rst) begin
      m_pos <= 0; m_el <= 0; m_sm <= 0; m_ss <= 0;
      m_rv <= 0; m_win <= 0; m_gm <= 0; m_gs <= 0;
    end else begin
      stepped = 0;
      ne = m_el;
      if (!m_ss) begin
        ne = m_el + 1;
        if (ne >= period(ui_in[3:0])) begin
          ne = 0;
          stepped = 1;
        end
      end
      np = !stepped ? m_pos : rev ? (m_pos + 5) % 6 : (m_pos + 1) % 6;
      m_el  <= ne;
      m_pos <= np;
      if (!m_ss) begin
        m_rv  <= 0;
        m_win <= 0;
      end else if (!m_rv) begin
        m_rv  <= 1;
        m_win <= m_gs[m_pos];
      end
      m_ss <= m_sm; m_sm <= ui_in[7];
      m_gs <= m_gm; m_gm <= uio_in[5:0];
    end
  end

  always @(negedge clk) begin
    check("model_uo", uo_out, {m_win, !m_ss, 6'(1 << m_pos)});
    check("model_uio", uio_out, {m_rv, m_rv & !m_win, 6'b0});
    check("model_oe", uio_oe, 8'hC0);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] codes [8] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h8, 4'h5, 4'hF};
    repeat (10) @(negedge clk);
    check("rst_uo", uo_out, 8'h41);
    check("rst_uio", uio_out, 8'h00);
    check("rst_oe", uio_oe, 8'hC0);
    rst = 1'b0;
    check("release_pos0", uo_out, 8'h41);
    ui_in = 8'h05;
    cyc(175);
    check("invalid_code_3_steps", uo_out, 8'h48);
    cyc(150);
    check("wrap_to_0", uo_out, 8'h41);
    ui_in = 8'h85;
    cyc(3);
    check("stop_lose_uio", uio_out, 8'hC0);
    check("stop_lose_uo", uo_out, 8'h01);
    cyc(250);
    check("stop_holds_pos", uo_out, 8'h01);
    uio_in = 8'h3F;
    ui_in = 8'h05;
    cyc(3);
    check("resume_clear", uio_out, 8'h00);
    check("resume_running", {7'b0, uo_out[6]}, 8'h01);
    cyc(250);
    ui_in = 8'h85;
    cyc(3);
    check("all_guess_win", {7'b0, uo_out[7]}, 8'h01);
    check("all_guess_uio", uio_out, 8'h80);
    uio_in = 8'h00;
    cyc(500);
    check("win_held", {7'b0, uo_out[7]}, 8'h01);
    check("win_held_uio", uio_out, 8'h80);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    ui_in = 8'h08;
    cyc(50);
    check("fast_10_steps", uo_out, 8'h50);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    ui_in = 8'h40;
    cyc(50);
`ifdef LEDSPINNER_DIR_EN
    check("reverse_step", uo_out, 8'h60);
`else
    check("dir_ignored", uo_out, 8'h42);
`endif
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 2) ui_in[3:0] = codes[$urandom_range(0, 7)];
      if ($urandom_range(0, 99) < 2) ui_in[6:4] = 3'($urandom);
      if ($urandom_range(0, 149) == 0) ui_in[7] = ~ui_in[7];
      if ($urandom_range(0, 19) == 0) uio_in = 8'($urandom);
      if (i == 2000) begin
        #3 rst = 1'b1;
        #5 rst = 1'b0;
      end
      @(negedge clk);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
